// File: rtl/alu_pkg.sv
// Purpose: shared ALU opcode encoding and default datapath width for the ALU arbiter slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int OP_W          = 3;
    localparam int WORD_SIZE_DEF = 16;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SLL  = 3'd1;
    localparam logic [OP_W-1:0] OP_SLT  = 3'd2;
    localparam logic [OP_W-1:0] OP_SLTU = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_SR   = 3'd5;
    localparam logic [OP_W-1:0] OP_OR   = 3'd6;
    localparam logic [OP_W-1:0] OP_AND  = 3'd7;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin grant; first set request bit at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none here; the caller qualifies the grant with its own accept condition.
// Ports: req (request vector), ptr (highest-priority index), grant (one-hot or zero),
//        grant_id (index of the granted bit, 0 when none), grant_any (some request granted).
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        // Walk the ring starting at ptr; the first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: shares one ALU between NUM_REQ valid/ready requesters with round-robin arbitration.
// Latency: 1 cycle from accept edge to registered result; full throughput via pass-through.
// Backpressure: no request accepted while the response slot is full and its owner is not ready.
// Ports: clk/rst_n; req_valid/req_ready with packed req_a/req_b/req_op per requester;
//        resp_valid (one-hot to owner)/resp_ready, shared resp_data and resp_id.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NUM_REQ   = 2,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_a,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]     req_op,
    output logic [NUM_REQ-1:0]          resp_valid,
    input  logic [NUM_REQ-1:0]          resp_ready,
    output logic [WORD_SIZE-1:0]        resp_data,
    output logic [ID_W-1:0]             resp_id
);

    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_any;
    logic [ID_W-1:0]      rr_ptr;
    logic                 slot_full;
    logic                 can_accept;
    logic                 accept;
    logic                 consume;
    logic [WORD_SIZE-1:0] alu_a;
    logic [WORD_SIZE-1:0] alu_b;
    logic [OP_W-1:0]      alu_op;
    logic [WORD_SIZE-1:0] alu_out;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    // Slot can take a new result if empty, or if the owner drains it this same cycle.
    assign can_accept = !slot_full || resp_ready[resp_id];
    assign consume    = slot_full && resp_ready[resp_id];

    // rst_n gating keeps req_ready low during reset even though the slot reads empty.
    assign req_ready = (rst_n && can_accept) ? grant : '0;
    assign accept    = rst_n && can_accept && grant_any;

    always_comb begin
        resp_valid = '0;
        if (slot_full) begin
            resp_valid[resp_id] = 1'b1;
        end
    end

    // Operand mux steered by the grant index; when nothing is granted the result is unused.
    always_comb begin
        alu_a  = req_a[int'(grant_id)*WORD_SIZE +: WORD_SIZE];
        alu_b  = req_b[int'(grant_id)*WORD_SIZE +: WORD_SIZE];
        alu_op = req_op[int'(grant_id)*OP_W +: OP_W];
    end

    // Shifts use the whole of alu_b: a shift count >= WORD_SIZE shifts every bit out.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            OP_ADD:  alu_out = alu_a + alu_b;
            OP_SLL:  alu_out = alu_a << alu_b;
            OP_SLT:  alu_out = {{(WORD_SIZE-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            OP_SLTU: alu_out = {{(WORD_SIZE-1){1'b0}}, (alu_a < alu_b)};
            OP_XOR:  alu_out = alu_a ^ alu_b;
            OP_SR:   alu_out = alu_a >> alu_b;
            OP_OR:   alu_out = alu_a | alu_b;
            OP_AND:  alu_out = alu_a & alu_b;
            default: alu_out = '0;
        endcase
    end

    // Response slot and round-robin pointer. The pointer only moves on accept so an
    // unserved requester keeps its place in the rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full <= 1'b0;
            resp_data <= '0;
            resp_id   <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            slot_full <= 1'b1;
            resp_data <= alu_out;
            resp_id   <= grant_id;
            rr_ptr    <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end else if (consume) begin
            slot_full <= 1'b0;
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between NUM_REQ independent requesters, such as the execute stage, the address-generation unit and the debug port.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- A round-robin policy grants at most one request per cycle. The ALU result is registered in a single-entry response slot, giving 1-cycle latency and full throughput.
- Sits between the requesting pipeline stages and the ALU datapath.

Parameters:
- WORD_SIZE, 16, operand and result width.
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) with a minimum of 1, width of the owner/pointer registers (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted (one-hot or zero).
- req_a  in  NUM_REQ*WORD_SIZE  packed operand A; requester i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- req_b  in  NUM_REQ*WORD_SIZE  packed operand B, same packing as req_a.
- req_op  in  NUM_REQ*3  packed ALU opcode; requester i occupies bits [i*3 +: 3].
- resp_valid  out  NUM_REQ  one-hot response valid to the owning requester.
- resp_ready  in  NUM_REQ  per-requester response consume.
- resp_data  out  WORD_SIZE  registered ALU result, shared by all requesters.
- resp_id  out  ID_W  index of the requester that owns the current response.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0, slot_full=0.
  - Any pending result is discarded, with no response delivered.
  - req_ready=0 while rst_n=0.
- Slot states:
  - EMPTY (slot_full=0) goes to FULL when a request is accepted.
  - FULL goes to EMPTY when the owner consumes the result (resp_valid[resp_id] & resp_ready[resp_id]) and no new request is accepted that cycle.
  - FULL stays FULL when the owner consumes and a new request is accepted in the same cycle (pass-through).
- can_accept = !slot_full | resp_ready[resp_id].
- Grant:
  - The winner is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
  - req_ready[winner] = can_accept; all other req_ready bits are 0.
  - req_ready is combinational from req_valid, rr_ptr, slot_full and resp_ready. It must not depend on req_a/req_b/req_op.
- Accept cycle (req_valid[w] & req_ready[w]):
  - The winner's a, b and op drive the ALU.
  - On the next edge: resp_data <= ALU out, resp_id <= w, slot_full <= 1, rr_ptr <= (w+1) mod NUM_REQ.
- Latency and throughput:
  - The result is visible exactly 1 cycle after the accept edge.
  - Back-to-back accepts are allowed every cycle when responses are consumed immediately.
- rr_ptr changes only on accept. With no accept it holds, so an unserved requester keeps priority order.
- resp_valid = slot_full ? (1 << resp_id) : 0, registered-equivalent.
- resp_data and resp_id hold stable while resp_valid is set and the response is not consumed.
- resp_ready bits of non-owners are ignored.
- Requester rules (checked by assertions in the bench, not enforced by RTL):
  - Once req_valid is high it stays high, with a/b/op stable, until req_ready.
  - The arbiter never drops or duplicates a request.
- ALU semantics:
  - Opcodes: ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SR=5 (logical), OR=6, AND=7.
  - Results are WORD_SIZE wide. ADD wraps modulo 2^WORD_SIZE.
  - SLT/SLTU return 0 or 1, zero-extended.
  - Shifts use the full b value: a shift amount of WORD_SIZE or more yields 0.
- Fairness: with all requesters continuously valid and responses consumed every cycle, grants rotate strictly 0,1,...,NUM_REQ-1,0,...
- Starvation bound: any valid requester is granted within NUM_REQ accepts.

Decomposition:
- Shared package alu_pkg: ALU opcode localparams (OP_ADD..OP_AND), opcode width constant (3), and WORD_SIZE default.
- One natural sub-module: rr_arbiter, which computes the combinational one-hot grant from the request vector and rr_ptr (parameter NUM_REQ).
- The ALU is instantiated once inside alu_arbiter. The slot/pointer registers live in the top.

Test Plan:
- Single request: req0 ADD a=16'h7FFF b=16'h0001 → req_ready[0]=1 same cycle; next cycle resp_valid=2'b01, resp_data=16'h8000, resp_id=0.
- Contention: both valid, rr_ptr=0, req0 SLT a=16'hFFFF b=0, req1 SLTU a=16'hFFFF b=0 → grant 0 then 1; responses 16'h0001 (id 0) then 16'h0000 (id 1).
- Backpressure: fill slot for req1 (XOR 16'hAAAA^16'h5555), hold resp_ready[1]=0 for 5 cycles with req0 valid → req_ready all 0; resp_data stays 16'hFFFF; resp_ready[0]=1 has no effect.
- Pass-through: slot full, owner consumes in the same cycle a new request is accepted → resp_valid never drops; results appear on consecutive cycles.
- Shifts: SLL a=16'h0001 b=15 → 16'h8000; SR a=16'h8000 b=16 → 16'h0000; SLL b=16'h0100 → 16'h0000.
- Reset mid-operation: assert rst_n=0 asynchronously while slot is full → resp_valid=0 immediately (no clock); after release rr_ptr=0, and req0 wins a tie with req1.
